counter_seq_checker: RTL
========================

Name: counter_seq_checker

Overview:
- Observer-side checker for the free-running 8-bit counter interface (value bus plus is-zero flag) used in the register-initialization bug cases.
- Samples the counter each cycle, predicts the next value, and reports value/flag mismatches.
- Also reports lock status, wrap events and a sticky fault.
- Sits beside the counter in the simulation/emulation harness and proves that the counter starts from a defined value and increments by exactly 1 modulo 2^W.

Parameters:
- W, 8, counter width in bits.
- CW, 16, width of error and wrap counters (saturating).
- MAX_MISS, 3, consecutive mismatching samples in TRACK that force FAULT (legal range 1..15).

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset for the checker.
- sample_en  input  1  counter_val/is_zero are valid this cycle.
- obs_reset  input  1  upstream counter's reset is asserted this cycle; the next sample must be 0.
- counter_val  input  W  observed counter value.
- is_zero  input  1  observed zero flag.
- clear_err  input  1  leaves FAULT and clears all error statistics.
- locked  output  1  checker is in TRACK.
- fault  output  1  checker is in FAULT.
- err_pulse  output  1  one-cycle pulse: the sample taken on the previous edge mismatched.
- err_val_flag  output  1  value mismatch component of err_pulse.
- err_zero_flag  output  1  is_zero inconsistent with counter_val (is_zero != (counter_val==0)).
- err_count  output  CW  total mismatching samples, saturating at all-ones.
- wrap_count  output  CW  matched all-ones->0 transitions not caused by obs_reset, saturating.
- last_err_val  output  W  counter_val of the most recent mismatching sample.
- expect_val  output  W  value predicted for the next sample.

Behaviour:
- Reset: rst sampled high forces state=ACQUIRE. All outputs are 0, as are the internal miss counter and exp_from_rst.
- All outputs are registered. Response appears one cycle after the sampling edge.
- Prediction after an accepted sample v:
  - expect_val = obs_reset ? 0 : v+1 (mod 2^W).
  - exp_from_rst = obs_reset.
- States:
  - ACQUIRE (locked=0): first cycle with sample_en=1:
    - zero-flag check only; err_zero_flag/err_pulse/err_count update if inconsistent;
    - load the prediction; go to TRACK.
  - TRACK (locked=1): each sample_en=1 cycle:
    - val_mis = (counter_val != expect_val); zero_mis per the is_zero rule; mismatch = val_mis | zero_mis.
    - Mismatch: err_pulse=1, flags set per component, err_count += 1 (saturating), last_err_val = counter_val, miss counter += 1.
    - The prediction is always reloaded from the observed value (resync), so an isolated glitch yields two value mismatches (bad sample, then the return).
    - No mismatch: miss counter cleared.
    - Matched sample with expect_val==0, exp_from_rst=0 and counter_val==0: wrap_count += 1 (saturating).
    - miss counter reaching MAX_MISS on this sample: go to FAULT on the same edge.
    - sample_en=0 in TRACK: continuity is lost. Go to ACQUIRE; no error; miss counter cleared.
  - FAULT (fault=1, locked=0): samples ignored, statistics frozen.
    - clear_err=1: clear err_count, wrap_count, last_err_val, flags and miss counter; go to ACQUIRE.
- clear_err outside FAULT clears the statistics only; the state is unchanged.
- clear_err together with a mismatching sample: the clear wins. Counters read 0 and the sample is not counted, but the state transition for that sample still applies.
- err_pulse, err_val_flag and err_zero_flag are 0 on any cycle without a counted mismatch.
- obs_reset asserted while sample_en=0: ignored (no sample, no prediction).
- rst has priority over every other input on every edge.

Test Plan:
1. Reset, then sample_en=1 with counter_val 0,1,2,…,10 and is_zero matching -> locked=1 from the 2nd output cycle, err_count=0, expect_val=11.
2. Run 0→255→0→5 continuously -> wrap_count=1, err_count=0. Then assert obs_reset with value 7; the next sample is 0 -> no error and wrap_count stays 1.
3. Sequence 20,21,99,23,24 -> err_pulse on 99 (last_err_val=99) and on 23, err_count=2, locked stays 1, no FAULT.
4. Samples val=0 with is_zero=0, then val=5 with is_zero=1 (otherwise sequential) -> err_zero_flag=1 and err_val_flag=0 on each, err_count=2.
5. MAX_MISS=3, sequence 10,40,80,120 -> fault=1 after 120, locked=0. Further bad samples leave err_count=3. clear_err -> ACQUIRE, err_count=0. Resuming 0,1,2 -> locked=1.
6. Mid-TRACK, drop sample_en for 1 cycle, then resume at 200 -> locked falls then re-locks, no error. Separately, assert rst mid-sequence -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/counter_seq_checker.sv
// Observer for a free-running W-bit counter: predicts each next sample, flags value and
// zero-flag mismatches, and tracks lock, wrap and sticky-fault status.
module counter_seq_checker #(
    parameter int W        = 8,
    parameter int CW       = 16,
    parameter int MAX_MISS = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sample_en,
    input  logic          obs_reset,
    input  logic [W-1:0]  counter_val,
    input  logic          is_zero,
    input  logic          clear_err,
    output logic          locked,
    output logic          fault,
    output logic          err_pulse,
    output logic          err_val_flag,
    output logic          err_zero_flag,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] wrap_count,
    output logic [W-1:0]  last_err_val,
    output logic [W-1:0]  expect_val
);

    typedef enum logic [1:0] {S_ACQUIRE, S_TRACK, S_FAULT} state_t;

    localparam logic [3:0] MISS_LIMIT = 4'(MAX_MISS);

    state_t         state_q;
    logic [3:0]     miss_q;
    logic           exp_from_rst_q;
    logic           err_pulse_q;
    logic           err_val_flag_q;
    logic           err_zero_flag_q;
    logic [CW-1:0]  err_count_q;
    logic [CW-1:0]  wrap_count_q;
    logic [W-1:0]   last_err_val_q;
    logic [W-1:0]   expect_q;

    logic           val_mis;
    logic           zero_mis;
    logic           mismatch;
    logic [W-1:0]   pred_d;
    logic [3:0]     miss_d;
    logic [CW-1:0]  err_count_d;
    logic [CW-1:0]  wrap_count_d;

    always_comb begin
        val_mis      = (counter_val != expect_q);
        zero_mis     = (is_zero != (counter_val == '0));
        mismatch     = val_mis | zero_mis;
        pred_d       = obs_reset ? '0 : counter_val + W'(1);
        miss_d       = miss_q + 4'd1;
        err_count_d  = (err_count_q == '1) ? err_count_q : err_count_q + CW'(1);
        wrap_count_d = (wrap_count_q == '1) ? wrap_count_q : wrap_count_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= S_ACQUIRE;
            miss_q          <= '0;
            exp_from_rst_q  <= 1'b0;
            err_pulse_q     <= 1'b0;
            err_val_flag_q  <= 1'b0;
            err_zero_flag_q <= 1'b0;
            err_count_q     <= '0;
            wrap_count_q    <= '0;
            last_err_val_q  <= '0;
            expect_q        <= '0;
        end else begin
            err_pulse_q     <= 1'b0;
            err_val_flag_q  <= 1'b0;
            err_zero_flag_q <= 1'b0;
            case (state_q)
                S_ACQUIRE: begin
                    if (sample_en) begin
                        // No prediction exists yet, so only the flag/value consistency is checkable.
                        if (zero_mis) begin
                            err_pulse_q     <= 1'b1;
                            err_zero_flag_q <= 1'b1;
                            err_count_q     <= err_count_d;
                            last_err_val_q  <= counter_val;
                        end
                        expect_q       <= pred_d;
                        exp_from_rst_q <= obs_reset;
                        miss_q         <= '0;
                        state_q        <= S_TRACK;
                    end
                end
                S_TRACK: begin
                    if (sample_en) begin
                        if (mismatch) begin
                            err_pulse_q     <= 1'b1;
                            err_val_flag_q  <= val_mis;
                            err_zero_flag_q <= zero_mis;
                            err_count_q     <= err_count_d;
                            last_err_val_q  <= counter_val;
                            miss_q          <= miss_d;
                            if (miss_d >= MISS_LIMIT) begin
                                state_q <= S_FAULT;
                            end
                        end else begin
                            miss_q <= '0;
                            if (expect_q == '0 && !exp_from_rst_q) begin
                                wrap_count_q <= wrap_count_d;
                            end
                        end
                        // Always resync to the observed value so one glitch cannot cascade.
                        expect_q       <= pred_d;
                        exp_from_rst_q <= obs_reset;
                    end else begin
                        miss_q  <= '0;
                        state_q <= S_ACQUIRE;
                    end
                end
                S_FAULT: begin
                    if (clear_err) begin
                        state_q <= S_ACQUIRE;
                    end
                end
                default: state_q <= S_ACQUIRE;
            endcase
            // Placed last so the clear overrides any statistic update from this sample.
            if (clear_err) begin
                err_pulse_q     <= 1'b0;
                err_val_flag_q  <= 1'b0;
                err_zero_flag_q <= 1'b0;
                err_count_q     <= '0;
                wrap_count_q    <= '0;
                last_err_val_q  <= '0;
                miss_q          <= '0;
            end
        end
    end

    assign locked        = (state_q == S_TRACK);
    assign fault         = (state_q == S_FAULT);
    assign err_pulse     = err_pulse_q;
    assign err_val_flag  = err_val_flag_q;
    assign err_zero_flag = err_zero_flag_q;
    assign err_count     = err_count_q;
    assign wrap_count    = wrap_count_q;
    assign last_err_val  = last_err_val_q;
    assign expect_val    = expect_q;

endmodule
